// File: rtl/pea_pkg.sv
// PEA-side shared constants: datapath word width.
package pea_pkg;
  localparam int N_BITS = 16;
endpackage

// File: rtl/stream_intf_pkg.sv
// Stream-interface constants and the crossbar select type shared by the DMA-to-PEA crossbar.
package stream_intf_pkg;
  localparam int N_DMA_CH_PER_IN_STREAM  = 4;
  localparam int N_PEA_DIN_PER_IN_STREAM = 4;
  localparam int XBAR_FIFO_DEPTH         = 4;
  localparam int XBAR_SEL_W              = $clog2(N_DMA_CH_PER_IN_STREAM);

  typedef logic [XBAR_SEL_W-1:0] xbar_sel_t;
endpackage

// File: rtl/xbar_out_fifo.sv
// Per-output FIFO of the DMA-to-PEA crossbar: registered count, no fall-through, flush drops contents.
module xbar_out_fifo #(
  parameter  int DATA_W     = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  input  logic              flush
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: dout is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dma_pea_stream_xbar.sv
// Buffered DMA-channel to PEA-input crossbar with fork semantics and runtime mapping.
// Optional MAGE_XBAR_PERF_EN adds per-channel saturating stall counters (stall_cnt_o).
module dma_pea_stream_xbar
  import stream_intf_pkg::*;
  import pea_pkg::*;
#(
  parameter  int N_IN       = N_DMA_CH_PER_IN_STREAM,
  parameter  int N_OUT      = N_PEA_DIN_PER_IN_STREAM,
  parameter  int DATA_W     = N_BITS,
  parameter  int FIFO_DEPTH = XBAR_FIFO_DEPTH,
  localparam int SEL_W      = $clog2(N_IN),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [N_IN-1:0]             dma_valid_i,
  input  logic [N_IN-1:0][DATA_W-1:0] dma_data_i,
  output logic [N_IN-1:0]             dma_ready_o,
  output logic [N_OUT-1:0]            pea_valid_o,
  output logic [N_OUT-1:0][DATA_W-1:0] pea_data_o,
  input  logic [N_OUT-1:0]            pea_ready_i,
  input  logic                        cfg_we_i,
  input  logic [N_OUT-1:0][SEL_W-1:0] cfg_sel_i,
  input  logic [N_OUT-1:0]            cfg_en_i,
  input  logic                        flush_i,
  output logic                        busy_o
`ifdef MAGE_XBAR_PERF_EN
  ,
  output logic [N_IN-1:0][31:0]       stall_cnt_o
`endif
);

  logic [N_OUT-1:0][SEL_W-1:0]  sel_q;
  logic [N_OUT-1:0]             en_q;
  logic [N_OUT-1:0]             fifo_push;
  logic [N_OUT-1:0][DATA_W-1:0] fifo_din;
  logic [N_OUT-1:0]             fifo_full;
  logic [N_OUT-1:0]             fifo_empty;
  logic [CNT_W-1:0]             fifo_count [N_OUT];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sel_q <= '0;
      en_q  <= '0;
    end else if (cfg_we_i) begin
      sel_q <= cfg_sel_i;
      en_q  <= cfg_en_i;
    end
  end

  // A channel is ready only if it feeds at least one output and every output it feeds has room.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      logic mapped;
      logic room;
      mapped = 1'b0;
      room   = 1'b1;
      for (int j = 0; j < N_OUT; j++) begin
        if (en_q[j] && (sel_q[j] == SEL_W'(i))) begin
          mapped = 1'b1;
          if (fifo_full[j]) room = 1'b0;
        end
      end
      dma_ready_o[i] = !cfg_we_i && !flush_i && mapped && room;
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      fifo_din[j]  = dma_data_i[sel_q[j]];
      fifo_push[j] = en_q[j] && dma_valid_i[sel_q[j]] && dma_ready_o[sel_q[j]];
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    xbar_out_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .push   (fifo_push[j]),
      .din    (fifo_din[j]),
      .full   (fifo_full[j]),
      .pop    (pea_ready_i[j]),
      .dout   (pea_data_o[j]),
      .empty  (fifo_empty[j]),
      .count  (fifo_count[j]),
      .flush  (flush_i)
    );
  end

  assign pea_valid_o = ~fifo_empty;

  always_comb begin
    busy_o = 1'b0;
    for (int j = 0; j < N_OUT; j++) begin
      if (fifo_count[j] != '0) busy_o = 1'b1;
    end
  end

`ifdef MAGE_XBAR_PERF_EN
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_IN; i++) begin
      if (!rst_n_i || flush_i) begin
        stall_cnt_o[i] <= '0;
      end else if (dma_valid_i[i] && !dma_ready_o[i] && (stall_cnt_o[i] != 32'hFFFF_FFFF)) begin
        stall_cnt_o[i] <= stall_cnt_o[i] + 32'd1;
      end
    end
  end
`endif

endmodule
